// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch with a one-entry decode buffer and redirect kill.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h01000000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic [XLEN-1:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
    state_t          state;
    logic            kill;
    logic [XLEN-1:0] req_pc;
    logic            redir;
    assign redir     = redirect_valid && state != IDLE;
    assign imem_req  = !reset && state == FETCH;
    assign imem_addr = current_pc;
    assign next_pc   = reset ? RESET_PC :
                       redir ? {redirect_target[XLEN-1:2], 2'b00} :
                       (state == FETCH && imem_ready) ? current_pc + 32'd4 : current_pc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            kill        <= 1'b0;
            req_pc      <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: if (imem_ready) begin
                    req_pc <= current_pc;
                    kill   <= redir;
                    state  <= WAIT;
                end
                // a redirect seen while waiting poisons the response, even one arriving this cycle
                WAIT: if (imem_rvalid) begin
                    if (!(kill || redir)) begin
                        instr       <= imem_rdata;
                        instr_pc    <= req_pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        kill  <= 1'b0;
                        state <= FETCH;
                    end
                end else if (redir) begin
                    kill <= 1'b1;
                end
                HOLD: begin
                    if (instr_ready) fetch_count <= fetch_count + 32'd1;
                    if (instr_ready || redir) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized fetch traffic checked against a transaction-level fetch model.
module tb_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h01000000;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] current_pc, next_pc, imem_addr, imem_rdata, redirect_target, instr, instr_pc, fetch_count;
    logic        imem_req, imem_ready, imem_rvalid, redirect_valid, instr_valid, instr_ready;
    int          checks = 0, failures = 0;
    // model: pc, outstanding request (possibly stale), one-entry buffer, handoff count
    bit          m_started, m_out, m_stale, m_bv;
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt, m_raddr;
    int          m_wait, next_rst;
    int          p_ready[4] = '{100, 50, 70, 30};
    int          p_redir[4] = '{0, 10, 30, 5};
    int          p_ir[4]    = '{100, 40, 60, 20};
    int          w_max[4]   = '{0, 3, 1, 4};

    fetch_ctrl #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .current_pc(current_pc), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset)
        if (reset) current_pc <= RST_PC;
        else current_pc <= next_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_ready = 1'b1;
        redirect_valid = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_next_pc", next_pc, RST_PC);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        m_started = 0; m_out = 0; m_stale = 0; m_bv = 0;
        m_pc = RST_PC; m_instr = '0; m_ipc = '0; m_cnt = '0; m_raddr = '0; m_wait = 0;
    endtask

    initial begin
        bit          req_en, redir;
        logic [31:0] exp_next;
        int          seg;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_target = 0; instr_ready = 0;
        apply_reset();
        next_rst = 600;
        for (int i = 0; i < 2400; i++) begin
            seg = i / 600;
            if (i >= next_rst && m_out) begin
                apply_reset();
                next_rst += 600;
            end
            @(negedge clk);
            reset = 1'b0;
            imem_ready      = $urandom_range(0, 99) < p_ready[seg];
            imem_rvalid     = m_out ? (m_wait == 0) : ($urandom_range(0, 15) == 0);
            imem_rdata      = $urandom;
            redirect_valid  = $urandom_range(0, 99) < p_redir[seg];
            redirect_target = {8'h01, 24'($urandom)};
            instr_ready     = $urandom_range(0, 99) < p_ir[seg];
            #1;
            req_en   = m_started && !m_out && !m_bv;
            redir    = redirect_valid && m_started;
            exp_next = redir ? {redirect_target[31:2], 2'b00} :
                       (req_en && imem_ready) ? m_pc + 32'd4 : m_pc;
            check("imem_req", {31'b0, imem_req}, {31'b0, req_en});
            check("imem_addr", imem_addr, m_pc);
            check("next_pc", next_pc, exp_next);
            check("instr_valid", {31'b0, instr_valid}, {31'b0, m_bv});
            check("fetch_count", fetch_count, m_cnt);
            if (m_bv) begin
                check("instr", instr, m_instr);
                check("instr_pc", instr_pc, m_ipc);
            end
            if (req_en && imem_ready) begin
                m_out = 1; m_stale = redir; m_raddr = m_pc;
                m_wait = $urandom_range(0, w_max[seg]);
            end else if (m_out) begin
                if (imem_rvalid) begin
                    m_out = 0;
                    if (!(m_stale || redir)) begin
                        m_bv = 1; m_instr = imem_rdata; m_ipc = m_raddr;
                    end
                    m_stale = 0;
                end else begin
                    if (redir) m_stale = 1;
                    m_wait--;
                end
            end else if (m_bv) begin
                if (instr_ready) begin
                    m_cnt++;
                    m_bv = 0;
                end
                if (redir) m_bv = 0;
            end
            m_pc = exp_next;
            m_started = 1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
